// File: rtl/fp_arb.sv
// rtl/fp_arb.sv - time-shares one fp_add among N requesters; macro FP_ARB_RR_EN selects round-robin, else fixed priority
module fp_arb #(
  parameter  int EMSB = 7,
  parameter  int FMSB = 22,
  parameter  int N    = 4,
  localparam int W    = EMSB + FMSB + 3,
  localparam int GW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           enable,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_valid,
  output logic           fp_enable,
  output logic           fp_req,
  output logic [W-1:0]   fp_rx_data_1,
  output logic [W-1:0]   fp_rx_data_2,
  input  logic           fp_ack,
  input  logic [W-1:0]   fp_tx_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RETURN    = 3'd4
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_g;
  logic [GW-1:0] w_win;
  logic          w_any;
  logic          w_grant;
  logic          w_deliver;
  logic [N-1:0]  r_req_ready;
  logic [N-1:0]  r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [W-1:0]  r_rx_1;
  logic [W-1:0]  r_rx_2;
  logic          r_fp_req;
  logic          r_fp_enable;

  assign w_any = |req_valid;

`ifdef FP_ARB_RR_EN
  // Round-robin pointer: index where the next search starts, moved past the winner on each grant
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] w_rr_idx;

  // Pick the first requester at or after r_ptr (scan runs backwards so the nearest hit is kept last)
  always_comb begin
    w_win    = '0;
    w_rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_rr_idx = GW'((int'(r_ptr) + k) % N);
      if (req_valid[w_rr_idx]) begin
        w_win = w_rr_idx;
      end
    end
  end

  // Advance the pointer only when a grant is actually issued
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win == GW'(N - 1)) ? '0 : w_win + GW'(1);
    end
  end
`else
  // Fixed priority: lowest asserted index wins
  always_comb begin
    w_win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[GW'(k)]) begin
        w_win = GW'(k);
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; dropping enable abandons whatever is in flight
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_deliver = 1'b0;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any && fp_ack) begin
            w_next  = S_GRANT;
            w_grant = 1'b1;
          end
        end
        S_GRANT: begin
          w_next = S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!fp_ack) begin
            w_next = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (fp_ack) begin
            w_next    = S_RETURN;
            w_deliver = 1'b1;
          end
        end
        S_RETURN: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // Datapath: all outputs are registered on entry to GRANT / RETURN so pulses last one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_g         <= '0;
      r_req_ready <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_rx_1      <= '0;
      r_rx_2      <= '0;
      r_fp_req    <= 1'b0;
      r_fp_enable <= 1'b0;
    end else begin
      r_fp_enable <= enable;
      r_req_ready <= '0;
      r_out_valid <= '0;
      if (w_grant) begin
        r_g         <= w_win;
        r_req_ready <= ONE << w_win;
        r_rx_1      <= in_a[int'(w_win) * W +: W];
        r_rx_2      <= in_b[int'(w_win) * W +: W];
        r_fp_req    <= ~r_fp_req;
      end
      if (w_deliver) begin
        r_out_data  <= fp_tx_data;
        r_out_valid <= ONE << r_g;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign fp_enable    = r_fp_enable;
  assign fp_req       = r_fp_req;
  assign fp_rx_data_1 = r_rx_1;
  assign fp_rx_data_2 = r_rx_2;

endmodule

// File: doc/fp_arb.md
FP_ARB -- requirements
Module: fp_arb

Interface
REQ-001 Parameter EMSB, default 7, exponent field MSB; it SHALL be passed unchanged to the shared fp_add.
REQ-002 Parameter FMSB, default 22, fraction field MSB; word width W = EMSB+FMSB+3, which is 32 by default.
REQ-003 Parameter N, default 4, number of requesters, legal range 2..8.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  the block's only clock; reset is asynchronous and active-low.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  block enable.
- req_valid  in  N  per-requester operation request.
- req_ready  out  N  one-cycle grant/accept pulse.
- in_a  in  N*W  packed operand 1; requester i occupies bits [i*W +: W].
- in_b  in  N*W  packed operand 2, same packing as in_a.
- out_data  out  W  result word.
- out_valid  out  N  one-cycle result pulse to the owning requester.
- fp_enable  out  1  drives the fp_add enable input.
- fp_req  out  1  toggle request to fp_add.
- fp_rx_data_1  out  W  operand 1 to fp_add.
- fp_rx_data_2  out  W  operand 2 to fp_add.
- fp_ack  in  1  fp_add ack; high means fp_add is idle.
- fp_tx_data  in  W  fp_add result.

Function
REQ-005 The block SHALL time-share one fp_add among N requesters, with at most one operation in flight.
REQ-006 The FSM states SHALL be IDLE, GRANT, WAIT_BUSY, WAIT_DONE and RETURN.
REQ-007 IDLE SHALL go to GRANT when any req_valid bit is set and fp_ack=1; otherwise the FSM SHALL stay in IDLE.
REQ-008 On entry to GRANT:
- The winner g SHALL be latched.
- req_ready[g] SHALL be high for exactly that cycle.
- in_a[g] and in_b[g] SHALL be registered onto fp_rx_data_1 and fp_rx_data_2.
- fp_req SHALL invert.
- The next state SHALL be WAIT_BUSY.
REQ-009 WAIT_BUSY SHALL hold until fp_ack=0, then go to WAIT_DONE.
REQ-010 WAIT_DONE SHALL hold until fp_ack=1, then go to RETURN.
REQ-011 In RETURN, out_data SHALL take fp_tx_data, out_valid[g] SHALL pulse for one cycle, and the next state SHALL be IDLE.
REQ-012 fp_rx_data_1 and fp_rx_data_2 SHALL remain stable from GRANT until RETURN.
REQ-013 out_data SHALL hold its last value until the next RETURN.
REQ-014 Requester protocol: req_valid[i] SHALL be held until req_ready[i]; dropping it before grant cancels the request with no response.
REQ-015 A requester that keeps req_valid high after its grant SHALL be treated as a new request.
REQ-016 Latency from the req_ready pulse to the out_valid pulse SHALL be fp_add cycle count + 3 cycles.
REQ-017 At most one req_ready bit and at most one out_valid bit SHALL be high in any cycle.
REQ-018 Simultaneous requests SHALL be resolved by the policy in REQ-024.
REQ-019 fp_enable SHALL equal the registered enable.
REQ-020 When enable=0:
- The FSM SHALL return to IDLE next cycle.
- req_ready and out_valid SHALL be 0.
- No pending result SHALL be delivered, because the in-flight operation is abandoned.
- fp_req SHALL keep its value.

Reset
REQ-021 rstn=0 SHALL asynchronously clear: state to IDLE, g to 0, fp_req to 0, all data outputs to 0, req_ready and out_valid to 0, fp_enable to 0.
REQ-022 Reset in the middle of an operation SHALL discard that operation without emitting out_valid; the fp_add shares rstn and is reset together with the block.

Configuration
REQ-023 The macro FP_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 Arbitration policy:
- With FP_ARB_RR_EN defined, round-robin SHALL apply: search starts at (last g + 1) mod N, and the pointer SHALL update only on grant.
- Without the macro, fixed priority SHALL apply: the lowest index wins, and no pointer register SHALL exist.

Verification
Operands use the fp_dec encoding, bias 128: 1.0=0x40000000, 2.0=0x40800000, 3.0=0x40C00000.
REQ-025 Single request: req_valid=0001, in_a[0]=0x40000000, in_b[0]=0x40800000 -> one req_ready[0] pulse, then out_valid=0001 with out_data=0x40C00000 and latency per REQ-016.
REQ-026 Simultaneous requests with FP_ARB_RR_EN: req_valid=1111 held and dropped per grant -> grants in order 0,1,2,3, with exactly one operation in flight at a time.
REQ-027 Simultaneous requests without the macro: req_valid=0110 held -> requester 1 is served before requester 2; requester 2 is then served after requester 1 drops its request.
REQ-028 Zero operand: in_a[2]=0x00000000, in_b[2]=0x40800000 -> out_valid[2] pulses with out_data=0x40800000.
REQ-029 Reset mid-operation: rstn pulled low during WAIT_DONE -> all outputs read 0 immediately, no out_valid pulse, and the next request completes normally.
REQ-030 Enable dropped in WAIT_BUSY -> FSM returns to IDLE with no out_valid; after enable returns to 1, a new request completes correctly.
